clken_ctrl: RTL and testbench

Parametrised successor to the fixed-divisor clock-enable generator for the SAP CPU. It derives slow-clock enables (clken rising-edge enable, clken2 mid-period enable, slowclk square wave) from sysclk. Adds a runtime-loadable divisor, RUN/STEP/HALT modes, CPU-halt gating and a clken pulse counter. It sits between the board clock and the CPU/front-panel logic.

---
 rtl/clken_pkg.sv | 21 ++
 rtl/clken_step_sync.sv | 61 ++++++
 rtl/clken_ctrl.sv | 152 +++++++++++++++
 tb/tb_clken_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// Shared types and constants for the clock-enable controller.
package clken_pkg;

  // Operating mode as presented on the mode input; 2'b11 behaves as HALT.
  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10
  } mode_e;

  // Controller state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  // Smallest usable divisor; smaller loads are clamped up to this.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clken_step_sync.sv
// Input conditioning for the front-panel step button and the CPU halt line.
// Optional 2-flop synchronizers are built when CLKEN_STEP_SYNC_EN is defined;
// otherwise both inputs are taken as already synchronous to sysclk.
// The step rising-edge detector is present in both builds.
module clken_step_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic step_req,
  input  logic hlt,
  output logic step_edge,
  output logic hlt_s
);

  logic step_s;
  logic step_prev_q, step_prev_d;

`ifdef CLKEN_STEP_SYNC_EN
  logic [1:0] step_sync_q, step_sync_d;
  logic [1:0] hlt_sync_q, hlt_sync_d;

  // Shift each asynchronous input through its two-stage synchronizer.
  always_comb begin
    step_sync_d = {step_sync_q[0], step_req};
    hlt_sync_d  = {hlt_sync_q[0], hlt};
  end

  // Synchronizer registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      step_sync_q <= '0;
      hlt_sync_q  <= '0;
    end else begin
      step_sync_q <= step_sync_d;
      hlt_sync_q  <= hlt_sync_d;
    end
  end

  assign step_s = step_sync_q[1];
  assign hlt_s  = hlt_sync_q[1];
`else
  assign step_s = step_req;
  assign hlt_s  = hlt;
`endif

  // Remember the previous step level for edge detection.
  always_comb begin
    step_prev_d = step_s;
  end

  // Edge-detect history register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step_prev_d;
    end
  end

  assign step_edge = step_s & ~step_prev_q;

endmodule

// File: rtl/clken_ctrl.sv
// Slow clock-enable generator for the SAP CPU: runtime-loadable divisor,
// RUN / STEP / HALT modes, CPU halt gating and a clken pulse counter.
// Build option: CLKEN_STEP_SYNC_EN adds 2-flop synchronizers on step_req/hlt
// (see clken_step_sync).
module clken_ctrl
  import clken_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 8,
  parameter int CNT_W       = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic             hlt,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             clken,
  output logic             clken2,
  output logic             slowclk,
  output logic             running,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic step_edge;
  logic hlt_s;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic [DIV_W-1:0] half_d;
  logic             wrap;
  logic             clken_q, clken_d;
  logic             clken2_q, clken2_d;
  logic             slowclk_q, slowclk_d;
  logic             running_q, running_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  clken_step_sync u_step_sync (
    .sysclk    (sysclk),
    .reset     (reset),
    .step_req  (step_req),
    .hlt       (hlt),
    .step_edge (step_edge),
    .hlt_s     (hlt_s)
  );

  // Next-state logic: mode FSM, period counter, divisor handoff and outputs.
  // Outputs are computed from the next state so the registered pulses line up
  // with the cycle that holds the matching counter value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    wrap       = (cnt_q == div_cur_q - ONE);

    if (div_load) begin
      div_pend_d = (div_in < MIN_D) ? MIN_D : div_in;
    end

    case (state_q)
      ST_IDLE: begin
        // Counter parked at 0, so a pending divisor may be adopted here.
        cnt_d     = '0;
        div_cur_d = div_pend_q;
        if (mode == MODE_RUN && !hlt_s) begin
          state_d = ST_RUN;
        end else if (mode == MODE_STEP && step_edge && !hlt_s) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          cnt_d     = '0;
          div_cur_d = div_pend_q;
          if (mode != MODE_RUN || hlt_s) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_STEP: begin
        if (wrap) begin
          cnt_d     = '0;
          div_cur_d = div_pend_q;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    half_d    = div_cur_d >> 1;
    clken_d   = (state_d != ST_IDLE) && (cnt_d == div_cur_d - ONE);
    clken2_d  = (state_d != ST_IDLE) && (cnt_d == half_d - ONE);
    running_d = (state_d != ST_IDLE);

    // clken and clken2 never coincide because H-1 < D-1 for every D >= 2.
    slowclk_d = slowclk_q;
    if (clken_q) begin
      slowclk_d = 1'b1;
    end else if (clken2_q) begin
      slowclk_d = 1'b0;
    end

    cycles_d = cycles_q + CNT_W'(clken_q);
  end

  // State and output registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_cur_q  <= DEF_DIV;
      div_pend_q <= DEF_DIV;
      clken_q    <= 1'b0;
      clken2_q   <= 1'b0;
      slowclk_q  <= 1'b0;
      running_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      clken_q    <= clken_d;
      clken2_q   <= clken2_d;
      slowclk_q  <= slowclk_d;
      running_q  <= running_d;
      cycles_q   <= cycles_d;
    end
  end

  assign clken   = clken_q;
  assign clken2  = clken2_q;
  assign slowclk = slowclk_q;
  assign running = running_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_clken_ctrl.sv
// Directed bench for clken_ctrl: a cycle table for RUN, divisor reload and
// clamping, plus hand sequences for STEP, halt gating and mid-period reset.
module tb_clken_ctrl;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        step_req;
  logic        hlt;
  logic [7:0]  div_in;
  logic        div_load;
  logic        clken;
  logic        clken2;
  logic        slowclk;
  logic        running;
  logic [15:0] cycles;

  int n_tests = 0;
  int n_fail  = 0;

  clken_ctrl #(.DIV_W(8), .DEFAULT_DIV(8), .CNT_W(16)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .mode     (mode),
    .step_req (step_req),
    .hlt      (hlt),
    .div_in   (div_in),
    .div_load (div_load),
    .clken    (clken),
    .clken2   (clken2),
    .slowclk  (slowclk),
    .running  (running),
    .cycles   (cycles)
  );

  always #5 sysclk = ~sysclk;

  // One table row: inputs held for ncyc edges (div_load only on the first),
  // expected outputs sampled after the last edge.
  typedef struct {
    logic [1:0] mode;
    logic       ld;
    logic [7:0] div;
    int         ncyc;
    logic       e_clken;
    logic       e_clken2;
    logic       e_slow;
    logic       e_run;
    int         e_cycles;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] m, input logic ld, input logic [7:0] d,
                     input int n, input logic c, input logic c2, input logic s,
                     input logic r, input int cy);
    vec_t v;
    v.mode = m; v.ld = ld; v.div = d; v.ncyc = n;
    v.e_clken = c; v.e_clken2 = c2; v.e_slow = s; v.e_run = r; v.e_cycles = cy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    mode = 2'b00; step_req = 1'b0; hlt = 1'b0; div_in = 8'd0; div_load = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Edges until the next clken is seen (1 = the very next edge); -1 if none.
  task automatic first_clken(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (clken === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_ck;
    int n_ck2;

    // RUN D=8, mid-period load of 5, clamp of 0 and 1 to 2, then HALT.
    add(2'b01, 0, 0, 1, 0, 0, 0, 1, 0);
    add(2'b01, 0, 0, 3, 0, 1, 0, 1, 0);
    add(2'b01, 0, 0, 4, 1, 0, 0, 1, 0);
    add(2'b01, 0, 0, 1, 0, 0, 1, 1, 1);
    add(2'b01, 0, 0, 3, 0, 1, 1, 1, 1);
    add(2'b01, 0, 0, 1, 0, 0, 0, 1, 1);
    add(2'b01, 0, 0, 3, 1, 0, 0, 1, 1);
    add(2'b01, 0, 0, 1, 0, 0, 1, 1, 2);
    add(2'b01, 1, 5, 2, 0, 0, 1, 1, 2);
    add(2'b01, 0, 0, 1, 0, 1, 1, 1, 2);
    add(2'b01, 0, 0, 4, 1, 0, 0, 1, 2);
    add(2'b01, 0, 0, 1, 0, 0, 1, 1, 3);
    add(2'b01, 0, 0, 1, 0, 1, 1, 1, 3);
    add(2'b01, 0, 0, 1, 0, 0, 0, 1, 3);
    add(2'b01, 0, 0, 2, 1, 0, 0, 1, 3);
    add(2'b01, 0, 0, 1, 0, 0, 1, 1, 4);
    add(2'b01, 0, 0, 1, 0, 1, 1, 1, 4);
    add(2'b01, 0, 0, 3, 1, 0, 0, 1, 4);
    add(2'b01, 1, 0, 1, 0, 0, 1, 1, 5);
    add(2'b01, 1, 1, 1, 0, 1, 1, 1, 5);
    add(2'b01, 0, 0, 3, 1, 0, 0, 1, 5);
    add(2'b01, 0, 0, 1, 0, 1, 1, 1, 6);
    add(2'b01, 0, 0, 1, 1, 0, 0, 1, 6);
    add(2'b01, 0, 0, 1, 0, 1, 1, 1, 7);
    add(2'b01, 0, 0, 1, 1, 0, 0, 1, 7);
    add(2'b00, 0, 0, 1, 0, 0, 1, 0, 8);
    add(2'b00, 0, 0, 3, 0, 0, 1, 0, 8);

    // Reset state.
    do_reset();
    chk("rst.clken",   clken,   0);
    chk("rst.clken2",  clken2,  0);
    chk("rst.slowclk", slowclk, 0);
    chk("rst.running", running, 0);
    chk("rst.cycles",  cycles,  0);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      div_in = vecs[i].div;
      div_load = vecs[i].ld;
      tick();
      div_load = 1'b0;
      for (int k = 1; k < vecs[i].ncyc; k++) tick();
      chk($sformatf("v%0d.clken", i),   clken,   vecs[i].e_clken);
      chk($sformatf("v%0d.clken2", i),  clken2,  vecs[i].e_clken2);
      chk($sformatf("v%0d.slowclk", i), slowclk, vecs[i].e_slow);
      chk($sformatf("v%0d.running", i), running, vecs[i].e_run);
      chk($sformatf("v%0d.cycles", i),  cycles,  vecs[i].e_cycles);
    end

    // STEP mode: one period per step edge; edges in HALT or mid-step ignored.
    do_reset();
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    chk("halt_step.running", running, 0);
    mode = 2'b10; tick(); tick();
    chk("step_idle.running", running, 0);
    step_req = 1'b1; tick(); step_req = 1'b0;
    chk("step1.running", running, 1);
    n_ck = 0; n_ck2 = 0;
    for (int i = 0; i < 20; i++) begin
      step_req = (i == 3);
      tick();
      step_req = 1'b0;
      n_ck  += int'(clken);
      n_ck2 += int'(clken2);
    end
    chk("step1.n_clken",  n_ck,  1);
    chk("step1.n_clken2", n_ck2, 1);
    chk("step1.running_after", running, 0);
    chk("step1.cycles", cycles, 1);
    step_req = 1'b1; tick(); step_req = 1'b0;
    chk("step2.running", running, 1);
    n_ck = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_ck += int'(clken);
    end
    chk("step2.n_clken", n_ck, 1);
    chk("step2.cycles", cycles, 2);

    // hlt raised at cnt=3 lets the period finish, then holds IDLE.
    do_reset();
    mode = 2'b01;
    tick(); tick(); tick(); tick();
    chk("hlt.clken2_cnt3", clken2, 1);
    hlt = 1'b1;
    tick(); tick(); tick(); tick();
    chk("hlt.clken_completes", clken, 1);
    tick();
    chk("hlt.running_off", running, 0);
    chk("hlt.cycles", cycles, 1);
    n_ck = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_ck += int'(clken) + int'(clken2);
    end
    chk("hlt.no_pulses", n_ck, 0);
    chk("hlt.still_idle", running, 0);
    hlt = 1'b0;
    first_clken(n);
    chk("hlt.restart_latency", n, 8);

    // Reset at cnt=5 with a pending load of 5 discards it.
    do_reset();
    mode = 2'b01;
    for (int i = 0; i < 9; i++) tick();
    chk("rstmid.cycles_before", cycles, 1);
    div_in = 8'd5; div_load = 1'b1; tick(); div_load = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rstmid.running_before", running, 1);
    reset = 1'b1;
    #1;
    chk("rstmid.clken",   clken,   0);
    chk("rstmid.clken2",  clken2,  0);
    chk("rstmid.slowclk", slowclk, 0);
    chk("rstmid.running", running, 0);
    chk("rstmid.cycles",  cycles,  0);
    tick();
    reset = 1'b0;
    first_clken(n);
    chk("rstmid.first_period", n, 8);
    first_clken(n);
    chk("rstmid.second_period", n, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
